// File: rtl/sync_fifo_buf_if.sv
// Purpose : handshake/data bundle between a producer/consumer and sync_fifo_buf.
// Latency : n/a (wiring only).
// Backpressure: FULL/EMPTY returned to the master; requests against them are dropped and flagged.
//
// Signals
//   W_DATA, W_INC, W_PERR_INJ  write side (master -> FIFO)
//   R_INC, FLAG_CLR            read request and sticky-flag clear (master -> FIFO)
//   R_DATA, R_VALID, R_PERR    registered read data, 1-cycle valid, parity error (FIFO -> master)
//   FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW  status (FIFO -> master)
interface sync_fifo_buf_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int ADDRSIZE   = 3
);
    logic [FIFO_WIDTH-1:0] W_DATA;
    logic                  W_INC;
    logic                  W_PERR_INJ;
    logic                  R_INC;
    logic                  FLAG_CLR;
    logic [FIFO_WIDTH-1:0] R_DATA;
    logic                  R_VALID;
    logic                  R_PERR;
    logic                  FULL;
    logic                  EMPTY;
    logic                  ALMOST_FULL;
    logic                  ALMOST_EMPTY;
    logic [ADDRSIZE:0]     COUNT;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;

    modport master (
        output W_DATA, W_INC, W_PERR_INJ, R_INC, FLAG_CLR,
        input  R_DATA, R_VALID, R_PERR, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  W_DATA, W_INC, W_PERR_INJ, R_INC, FLAG_CLR,
        output R_DATA, R_VALID, R_PERR, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/sync_fifo_buf.sv
// Purpose : single-clock FIFO with registered read data, occupancy, thresholds and sticky error flags.
// Latency : read data valid 1 cycle after an accepted read request; status registered every edge.
// Backpressure: writes dropped while FULL (OVERFLOW set), reads dropped while EMPTY (UNDERFLOW set).
//
// Ports
//   CLK  single clock, rising edge
//   RST  synchronous reset, active-high (memory array itself is not cleared)
//   bus  sync_fifo_buf_if.slave: write/read requests in, data and status out
// Optional feature: define SYNC_FIFO_PARITY_EN to store an even-parity bit per entry
// (W_PERR_INJ flips it) and report mismatches on R_PERR; otherwise R_PERR is tied 0.
module sync_fifo_buf #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDRSIZE   = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic            CLK,
    input  logic            RST,
    sync_fifo_buf_if.slave  bus
);

`ifdef SYNC_FIFO_PARITY_EN
    localparam int MEM_W = FIFO_WIDTH + 1;
`else
    localparam int MEM_W = FIFO_WIDTH;
`endif

    localparam logic [ADDRSIZE:0] AF_L = (ADDRSIZE+1)'(AF_LEVEL);
    localparam logic [ADDRSIZE:0] AE_L = (ADDRSIZE+1)'(AE_LEVEL);

    logic [MEM_W-1:0]      mem [FIFO_DEPTH];
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      rd_word;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDRSIZE:0]     wptr, rptr;
    logic [ADDRSIZE:0]     wptr_nxt, rptr_nxt, count_nxt;
    logic                  wr_acc, rd_acc;

    logic [FIFO_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;
    logic                  full_q, empty_q, af_q, ae_q;
    logic [ADDRSIZE:0]     count_q;
    logic                  ovf_q, udf_q;

    // Acceptance uses the registered (pre-edge) flags: no fall-through and
    // no write-into-full even when a read frees a slot in the same cycle.
    assign wr_acc = bus.W_INC && !full_q;
    assign rd_acc = bus.R_INC && !empty_q;

    assign wptr_nxt  = wptr + {{ADDRSIZE{1'b0}}, wr_acc};
    assign rptr_nxt  = rptr + {{ADDRSIZE{1'b0}}, rd_acc};
    assign count_nxt = wptr_nxt - rptr_nxt;

`ifdef SYNC_FIFO_PARITY_EN
    assign wr_word = {(^bus.W_DATA) ^ bus.W_PERR_INJ, bus.W_DATA};
`else
    assign wr_word = bus.W_DATA;
    logic unused_perr_inj;
    assign unused_perr_inj = bus.W_PERR_INJ;
`endif

    assign rd_word = mem[rptr[ADDRSIZE-1:0]];

    // Storage: no reset; a write coinciding with RST is discarded.
    always_ff @(posedge CLK) begin
        if (!RST && wr_acc) begin
            mem[wptr[ADDRSIZE-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr      <= '0;
            rptr      <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            r_valid_q <= rd_acc;
            if (rd_acc) begin
                r_data_q <= rd_word[FIFO_WIDTH-1:0];
            end

            count_q <= count_nxt;
            full_q  <= (wptr_nxt[ADDRSIZE] != rptr_nxt[ADDRSIZE]) &&
                       (wptr_nxt[ADDRSIZE-1:0] == rptr_nxt[ADDRSIZE-1:0]);
            empty_q <= (wptr_nxt == rptr_nxt);
            af_q    <= (count_nxt >= AF_L);
            ae_q    <= (count_nxt <= AE_L);

            // Setting condition has priority over the clear.
            if (bus.W_INC && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.FLAG_CLR) begin
                ovf_q <= 1'b0;
            end
            if (bus.R_INC && empty_q) begin
                udf_q <= 1'b1;
            end else if (bus.FLAG_CLR) begin
                udf_q <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    logic r_perr_q;
    // Stored word including parity bit must XOR to zero when intact.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_perr_q <= 1'b0;
        end else begin
            r_perr_q <= rd_acc && (^rd_word);
        end
    end
    assign bus.R_PERR = r_perr_q;
`else
    assign bus.R_PERR = 1'b0;
`endif

    assign bus.R_DATA       = r_data_q;
    assign bus.R_VALID      = r_valid_q;
    assign bus.FULL         = full_q;
    assign bus.EMPTY        = empty_q;
    assign bus.ALMOST_FULL  = af_q;
    assign bus.ALMOST_EMPTY = ae_q;
    assign bus.COUNT        = count_q;
    assign bus.OVERFLOW     = ovf_q;
    assign bus.UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Purpose : directed, table-driven check of sync_fifo_buf (depth 8, width 8, AF 6, AE 2).
// Latency : each vector is driven on the falling edge and checked 1 time unit after the next rising edge.
// Backpressure: stimulus exercises writes into FULL and reads from EMPTY explicitly.
module tb_sync_fifo_buf;

`ifdef SYNC_FIFO_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic CLK;
    logic RST;

    sync_fifo_buf_if #(.FIFO_WIDTH(8), .ADDRSIZE(3)) bus ();

    sync_fifo_buf #(
        .FIFO_WIDTH(8), .FIFO_DEPTH(8), .ADDRSIZE(3), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst, w_inc;
        logic [7:0] w_dat;
        logic       r_inc, clr, inj;
        logic [3:0] count;
        logic       full, empty, af, ae, rv, chk_rd;
        logic [7:0] rdata;
        logic       perr, ovf, udf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   vidx   = 0;

    function automatic vec_t mk(
        input logic rst, w, input logic [7:0] d, input logic r, clr, inj,
        input logic [3:0] c, input logic f, e, af, ae, rv, chk, input logic [7:0] rd,
        input logic pe, ov, ud);
        vec_t v;
        v.rst = rst; v.w_inc = w; v.w_dat = d; v.r_inc = r; v.clr = clr; v.inj = inj;
        v.count = c; v.full = f; v.empty = e; v.af = af; v.ae = ae; v.rv = rv;
        v.chk_rd = chk; v.rdata = rd; v.perr = pe; v.ovf = ov; v.udf = ud;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge CLK);
        RST            = v.rst;
        bus.W_INC      = v.w_inc;
        bus.W_DATA     = v.w_dat;
        bus.R_INC      = v.r_inc;
        bus.FLAG_CLR   = v.clr;
        bus.W_PERR_INJ = v.inj;
        @(posedge CLK);
        #1;
        chk("COUNT",        vidx, 8'(bus.COUNT),        8'(v.count));
        chk("FULL",         vidx, 8'(bus.FULL),         8'(v.full));
        chk("EMPTY",        vidx, 8'(bus.EMPTY),        8'(v.empty));
        chk("ALMOST_FULL",  vidx, 8'(bus.ALMOST_FULL),  8'(v.af));
        chk("ALMOST_EMPTY", vidx, 8'(bus.ALMOST_EMPTY), 8'(v.ae));
        chk("R_VALID",      vidx, 8'(bus.R_VALID),      8'(v.rv));
        chk("R_PERR",       vidx, 8'(bus.R_PERR),       8'(v.perr));
        chk("OVERFLOW",     vidx, 8'(bus.OVERFLOW),     8'(v.ovf));
        chk("UNDERFLOW",    vidx, 8'(bus.UNDERFLOW),    8'(v.udf));
        if (v.chk_rd) chk("R_DATA", vidx, bus.R_DATA, v.rdata);
        vidx++;
    endtask

    initial begin
        RST = 1'b0; bus.W_INC = 1'b0; bus.W_DATA = '0; bus.R_INC = 1'b0;
        bus.FLAG_CLR = 1'b0; bus.W_PERR_INJ = 1'b0;

        //                rst w  data  r  clr inj cnt f  e  af ae rv chk rdata pe ov ud
        // Reset state (R_DATA cleared)
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 8'h00, 0, 0, 0));
        // Fill with 0x11..0x88
        vecs.push_back(mk(0, 1, 8'h11, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h44, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h55, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h66, 0, 0, 0, 6, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h77, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h88, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
        // Write while full: dropped, OVERFLOW sticky; then clear
        vecs.push_back(mk(0, 1, 8'hAA, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
        // Drain in order
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 7, 0, 0, 1, 0, 1, 1, 8'h11, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 6, 0, 0, 1, 0, 1, 1, 8'h22, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 5, 0, 0, 0, 0, 1, 1, 8'h33, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 4, 0, 0, 0, 0, 1, 1, 8'h44, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 3, 0, 0, 0, 0, 1, 1, 8'h55, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 2, 0, 0, 0, 1, 1, 1, 8'h66, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 8'h77, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 8'h88, 0, 0, 0));
        // Read+write on empty: read rejected (no fall-through), R_DATA holds
        vecs.push_back(mk(0, 1, 8'h5C, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 8'h88, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 8'h5C, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 8'h5C, 0, 0, 0));
        foreach (vecs[i]) run_vec(vecs[i]);
        vecs.delete();

        // Steady state at COUNT=4 with simultaneous traffic across pointer wrap
        for (int i = 0; i < 4; i++)
            run_vec(mk(0, 1, 8'(8'hA0 + i), 0, 0, 0, 4'(i + 1), 0, 0, 0, (i < 2), 0, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < 20; i++)
            run_vec(mk(0, 1, 8'(8'hA4 + i), 1, 0, 0, 4, 0, 0, 0, 0, 1, 1, 8'(8'hA0 + i), 0, 0, 0));
        for (int i = 0; i < 4; i++)
            run_vec(mk(0, 0, 8'h00, 1, 0, 0, 4'(3 - i), 0, (i == 3), 0, (i >= 1), 1, 1,
                       8'(8'hB4 + i), 0, 0, 0));

        //                rst w  data  r  clr inj cnt f  e  af ae rv chk rdata pe ov ud
        // Underflow, refill to 5, then reset with pending requests
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 8'hB7, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h01, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h02, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h03, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h04, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h05, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, 1, 8'h99, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h3E, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 8'h3E, 0, 0, 0));
        // Parity: corrupted entry then clean entry
        vecs.push_back(mk(0, 1, 8'h0F, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h0F, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 8'h0F, PAR, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 8'h0F, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 8'h0F, 0, 0, 0));
        foreach (vecs[i]) run_vec(vecs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
